// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : hazard info in / latch control out for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_mio;
  logic             ex_wr;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic             mem_mio;
  logic             mem_ready;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_jump;
  logic             pc_en;
  logic             pc_sel;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_regwrite, ex_mio, ex_wr,
    output mem_rd, mem_regwrite, mem_mio, mem_ready, mem_branch, mem_zero, mem_jump,
    input  pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
    input  exmem_en, exmem_flush, memwb_en, memwb_flush,
    input  fwd_a, fwd_b, mem_timeout_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_regwrite, ex_mio, ex_wr,
    input  mem_rd, mem_regwrite, mem_mio, mem_ready, mem_branch, mem_zero, mem_jump,
    output pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
    output exmem_en, exmem_flush, memwb_en, memwb_flush,
    output fwd_a, fwd_b, mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush scheduler for memory waits, MEM-stage redirects
// and load-use hazards. Optional forwarding selects under HAZARD_FWD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] C_WAIT_LIMIT = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ABORT    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_pc_en, w_pc_sel;
  logic w_ifid_en, w_ifid_flush;
  logic w_idex_en, w_idex_flush;
  logic w_exmem_en, w_exmem_flush;
  logic w_memwb_en, w_memwb_flush;
  logic w_run_ctl;
  logic w_redirect;

  logic w_taken;
  logic w_ex_load;
  logic w_ex_hit;
  logic w_load_use;

  assign w_taken   = hz.mem_jump | (hz.mem_branch & hz.mem_zero);
  assign w_ex_load = hz.ex_mio & ~hz.ex_wr & hz.ex_regwrite;
  assign w_ex_hit  = (hz.ex_rd != 5'd0) &
                     ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

`ifdef HAZARD_FWD_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  // EX producer is one stage closer, so it takes priority over MEM.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] ex_rd, input logic ex_rw,
                                         input logic [4:0] mem_rd, input logic mem_rw);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_rw && (ex_rd != 5'd0) && (rs == ex_rd))
      sel = 2'b10;
    else if (mem_rw && (mem_rd != 5'd0) && (rs == mem_rd))
      sel = 2'b01;
    return sel;
  endfunction

  assign w_load_use = w_ex_load & w_ex_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else if (w_idex_en) begin
      if (w_idex_flush) begin
        r_fwd_a <= 2'b00;
        r_fwd_b <= 2'b00;
      end else begin
        r_fwd_a <= fwd_sel(hz.id_rs1, hz.ex_rd, hz.ex_regwrite, hz.mem_rd, hz.mem_regwrite);
        r_fwd_b <= fwd_sel(hz.id_rs2, hz.ex_rd, hz.ex_regwrite, hz.mem_rd, hz.mem_regwrite);
      end
    end
  end

  assign hz.fwd_a = r_fwd_a;
  assign hz.fwd_b = r_fwd_b;
`else
  logic w_mem_hit;

  // Without forwarding every RAW against EX or MEM must wait; WB is covered
  // by the register file writing before it is read.
  assign w_mem_hit  = hz.mem_regwrite & (hz.mem_rd != 5'd0) &
                      ((hz.id_use_rs1 & (hz.id_rs1 == hz.mem_rd)) |
                       (hz.id_use_rs2 & (hz.id_rs2 == hz.mem_rd)));
  assign w_load_use = (w_ex_load & w_ex_hit) | (hz.ex_regwrite & w_ex_hit) | w_mem_hit;

  assign hz.fwd_a = 2'b00;
  assign hz.fwd_b = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_pc_en       = 1'b1;
    w_pc_sel      = 1'b0;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_en     = 1'b1;
    w_idex_flush  = 1'b0;
    w_exmem_en    = 1'b1;
    w_exmem_flush = 1'b0;
    w_memwb_en    = 1'b1;
    w_memwb_flush = 1'b0;
    w_run_ctl     = 1'b0;
    w_redirect    = 1'b0;

    if (rst) begin
      w_next     = ST_RUN;
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (hz.mem_mio && !hz.mem_ready) begin
            w_next = ST_MEM_WAIT;
          end else begin
            w_run_ctl = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready) begin
            w_next    = ST_RUN;
            w_run_ctl = 1'b1;
          end else if (r_wait_cnt == C_WAIT_LIMIT) begin
            w_next = ST_ABORT;
          end
        end
        ST_ABORT: begin
          w_next        = ST_RUN;
          w_memwb_flush = 1'b1;
        end
        default: begin
          w_next = ST_RUN;
        end
      endcase

      // Any RUN/MEM_WAIT cycle not handed to run control is a freeze.
      if ((r_state != ST_ABORT) && !w_run_ctl) begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_memwb_flush = 1'b1;
      end

      if (w_run_ctl) begin
        if (w_taken) begin
          w_redirect    = 1'b1;
          w_pc_sel      = 1'b1;
          w_ifid_flush  = 1'b1;
          w_idex_flush  = 1'b1;
          w_exmem_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((r_state == ST_RUN) && (w_next == ST_MEM_WAIT))
        r_wait_cnt <= WC_W'(1);
      else if ((r_state == ST_MEM_WAIT) && (w_next == ST_MEM_WAIT))
        r_wait_cnt <= r_wait_cnt + WC_W'(1);
      else
        r_wait_cnt <= '0;

      if (r_state == ST_ABORT)
        r_err <= 1'b1;

      if (!w_pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      if (w_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.pc_en           = w_pc_en;
  assign hz.pc_sel          = w_pc_sel;
  assign hz.ifid_en         = w_ifid_en;
  assign hz.ifid_flush      = w_ifid_flush;
  assign hz.idex_en         = w_idex_en;
  assign hz.idex_flush      = w_idex_flush;
  assign hz.exmem_en        = w_exmem_en;
  assign hz.exmem_flush     = w_exmem_flush;
  assign hz.memwb_en        = w_memwb_en;
  assign hz.memwb_flush     = w_memwb_flush;
  assign hz.mem_timeout_err = r_err;
  assign hz.stall_cnt       = r_stall_cnt;
  assign hz.flush_cnt       = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam int TO = 16;

  // {pc_en,pc_sel, ifid_en,ifid_flush, idex_en,idex_flush, exmem_en,exmem_flush, memwb_en,memwb_flush}
  localparam logic [9:0] C_RST    = 10'b00_00_00_00_00;
  localparam logic [9:0] C_NORM   = 10'b10_10_10_10_10;
  localparam logic [9:0] C_FREEZE = 10'b00_00_00_00_01;
  localparam logic [9:0] C_LU     = 10'b00_00_11_10_10;
  localparam logic [9:0] C_REDIR  = 10'b11_11_11_11_10;
  localparam logic [9:0] C_ABORT  = 10'b10_10_10_10_11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  logic [9:0] ctl;
  assign ctl = {hz.pc_en, hz.pc_sel, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
                hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.memwb_flush};

  int checks   = 0;
  int failures = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet;
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_regwrite = 1'b0; hz.ex_mio = 1'b0; hz.ex_wr = 1'b0;
    hz.mem_rd = 5'd0; hz.mem_regwrite = 1'b0; hz.mem_mio = 1'b0; hz.mem_ready = 1'b0;
    hz.mem_branch = 1'b0; hz.mem_zero = 1'b0; hz.mem_jump = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    quiet();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load_use;
    hz.ex_mio = 1'b1; hz.ex_wr = 1'b0; hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd5;
    hz.id_rs1 = 5'd6; hz.id_use_rs1 = 1'b1; hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    quiet();
    #1;
    checks++; if (ctl !== C_RST) begin failures++; $display("FAIL rst_ctl got=%b exp=%b", ctl, C_RST); end
    tick();
    tick();
    checks++; if (hz.stall_cnt !== 4'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", hz.stall_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL rst_run_ctl got=%b exp=%b", ctl, C_NORM); end
    checks++; if ({hz.mem_timeout_err, hz.flush_cnt, hz.fwd_a, hz.fwd_b} !== 9'd0) begin
      failures++; $display("FAIL rst_regs got=%b exp=0", {hz.mem_timeout_err, hz.flush_cnt, hz.fwd_a, hz.fwd_b}); end
  endtask

  task automatic test_load_use;
    do_reset();
    set_load_use();
    #1;
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    quiet();
    #1;
    checks++; if (hz.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", hz.stall_cnt); end
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL lu_release got=%b exp=%b", ctl, C_NORM); end
    // load into x0 is never a hazard
    set_load_use();
    hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_NORM); end
    // store in EX writes no register
    set_load_use();
    hz.ex_wr = 1'b1; hz.ex_regwrite = 1'b0;
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL lu_store got=%b exp=%b", ctl, C_NORM); end
    quiet();
  endtask

  task automatic test_raw_fwd;
    do_reset();
    hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3; hz.id_use_rs1 = 1'b1;
    #1;
`ifdef HAZARD_FWD_EN
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL raw_ex_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    quiet();
    #1;
    checks++; if (hz.fwd_a !== 2'b10) begin failures++; $display("FAIL fwd_ex got=%b exp=10", hz.fwd_a); end
`else
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL raw_ex_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    quiet();
    #1;
    checks++; if (hz.fwd_a !== 2'b00) begin failures++; $display("FAIL fwd_ex got=%b exp=00", hz.fwd_a); end
`endif
    hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL raw_x0_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    quiet();
    #1;
    checks++; if (hz.fwd_a !== 2'b00) begin failures++; $display("FAIL fwd_x0 got=%b exp=00", hz.fwd_a); end
    hz.mem_regwrite = 1'b1; hz.mem_rd = 5'd7; hz.id_rs2 = 5'd7; hz.id_use_rs2 = 1'b1;
    hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd9; hz.mem_rd = 5'd7; hz.id_rs1 = 5'd9; hz.id_use_rs1 = 1'b0;
    #1;
`ifdef HAZARD_FWD_EN
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL raw_mem_ctl got=%b exp=%b", ctl, C_NORM); end
    tick();
    quiet();
    #1;
    checks++; if ({hz.fwd_a, hz.fwd_b} !== 4'b1001) begin failures++; $display("FAIL fwd_mem got=%b exp=1001", {hz.fwd_a, hz.fwd_b}); end
`else
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL raw_mem_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    quiet();
    #1;
    checks++; if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) begin failures++; $display("FAIL fwd_mem got=%b exp=0000", {hz.fwd_a, hz.fwd_b}); end
`endif
  endtask

  task automatic test_mem_wait;
    do_reset();
    hz.mem_mio = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_FREEZE) begin failures++; $display("FAIL wait_ctl[%0d] got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL wait_done got=%b exp=%b", ctl, C_NORM); end
    tick();
    quiet();
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL wait_back_run got=%b exp=%b", ctl, C_NORM); end
    checks++; if ({hz.mem_timeout_err, hz.stall_cnt} !== {1'b0, 4'd3}) begin
      failures++; $display("FAIL wait_err_stall got=%b exp=%b", {hz.mem_timeout_err, hz.stall_cnt}, {1'b0, 4'd3}); end
  endtask

  task automatic test_timeout;
    do_reset();
    hz.mem_mio = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      #1;
      checks++; if (ctl !== C_FREEZE) begin failures++; $display("FAIL to_freeze[%0d] got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    #1;
    checks++; if (ctl !== C_ABORT) begin failures++; $display("FAIL to_abort got=%b exp=%b", ctl, C_ABORT); end
    tick();
    quiet();
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL to_run got=%b exp=%b", ctl, C_NORM); end
    // 17 stall cycles saturate the 4-bit counter
    checks++; if (hz.stall_cnt !== 4'd15) begin failures++; $display("FAIL to_stall_sat got=%0d exp=15", hz.stall_cnt); end
    tick(); tick(); tick();
    checks++; if (hz.mem_timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", hz.mem_timeout_err); end
    do_reset();
    checks++; if (hz.mem_timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", hz.mem_timeout_err); end
  endtask

  task automatic test_redirect;
    do_reset();
    hz.mem_branch = 1'b1; hz.mem_zero = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_REDIR); end
    tick();
    hz.mem_zero = 1'b0;
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL br_not_taken got=%b exp=%b", ctl, C_NORM); end
    checks++; if (hz.flush_cnt !== 4'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", hz.flush_cnt); end
    tick();
    quiet();
    hz.mem_jump = 1'b1;
    set_load_use();
    #1;
    checks++; if (ctl !== C_REDIR) begin failures++; $display("FAIL jmp_lu_ctl got=%b exp=%b", ctl, C_REDIR); end
    tick();
    quiet();
    #1;
    checks++; if ({hz.flush_cnt, hz.stall_cnt} !== {4'd2, 4'd0}) begin
      failures++; $display("FAIL jmp_lu_cnts got=%b exp=%b", {hz.flush_cnt, hz.stall_cnt}, {4'd2, 4'd0}); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    hz.mem_mio = 1'b1; hz.mem_ready = 1'b0;
    tick();
    hz.mem_ready = 1'b1; hz.mem_branch = 1'b1; hz.mem_zero = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin failures++; $display("FAIL b2b_wait_redir got=%b exp=%b", ctl, C_REDIR); end
    tick();
    quiet();
    set_load_use();
    #1;
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL b2b_lu got=%b exp=%b", ctl, C_LU); end
    tick();
    quiet();
    #1;
    checks++; if ({hz.stall_cnt, hz.flush_cnt} !== {4'd2, 4'd1}) begin
      failures++; $display("FAIL b2b_cnts got=%b exp=%b", {hz.stall_cnt, hz.flush_cnt}, {4'd2, 4'd1}); end
  endtask

  task automatic test_rst_in_wait;
    do_reset();
    hz.mem_jump = 1'b1;
    tick();
    quiet();
    hz.mem_mio = 1'b1; hz.mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (ctl !== C_RST) begin failures++; $display("FAIL rw_rst_ctl got=%b exp=%b", ctl, C_RST); end
    tick();
    rst = 1'b0;
    quiet();
    #1;
    checks++; if (ctl !== C_NORM) begin failures++; $display("FAIL rw_run got=%b exp=%b", ctl, C_NORM); end
    checks++; if ({hz.mem_timeout_err, hz.stall_cnt, hz.flush_cnt} !== 9'd0) begin
      failures++; $display("FAIL rw_regs got=%b exp=0", {hz.mem_timeout_err, hz.stall_cnt, hz.flush_cnt}); end
  endtask

  task automatic test_saturation;
    do_reset();
    set_load_use();
    repeat (20) tick();
    quiet();
    #1;
    checks++; if (hz.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall got=%0d exp=15", hz.stall_cnt); end
    hz.mem_jump = 1'b1;
    repeat (18) tick();
    quiet();
    #1;
    checks++; if ({hz.flush_cnt, hz.stall_cnt} !== {4'd15, 4'd15}) begin
      failures++; $display("FAIL sat_flush got=%b exp=%b", {hz.flush_cnt, hz.stall_cnt}, {4'd15, 4'd15}); end
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_raw_fwd();
    test_mem_wait();
    test_timeout();
    test_redirect();
    test_back_to_back();
    test_rst_in_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
